// File: rtl/red_pitaya_pid_slew.sv
// rtl/red_pitaya_pid_slew.sv - per-channel min/max clamp and slew-rate limiter between PID and DAC
// Optional macro PID_SLEW_STAT_EN adds per-channel limit-event counters readable at 0x08.
module red_pitaya_pid_slew #(
    parameter int DW = 14,
    parameter int PW = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [DW-1:0] dat_a_i,
    input  logic [DW-1:0] dat_b_i,
    output logic [DW-1:0] dat_a_o,
    output logic [DW-1:0] dat_b_o,
    input  logic [31:0]   sys_addr,
    input  logic [31:0]   sys_wdata,
    input  logic          sys_wen,
    input  logic          sys_ren,
    output logic [31:0]   sys_rdata,
    output logic          sys_err,
    output logic          sys_ack
);
    logic [19:0]   addr;
    logic [3:0]    ctrl;
    logic [DW-1:0] din [2];
    logic [31:0]   rd_mux;
    logic          unused_bits;

    assign addr        = sys_addr[19:0];
    assign din[0]      = dat_a_i;
    assign din[1]      = dat_b_i;
    assign unused_bits = &{1'b0, sys_addr[31:20], sys_wdata[31:PW]};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            ctrl <= 4'h0;
        else if (sys_wen && addr == 20'h00)
            ctrl <= sys_wdata[3:0];
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        localparam logic [19:0] BASE = 20'h10 + 20'(ch) * 20'h10;

        logic [DW-1:0]        step_q, step_eff;
        logic [PW-1:0]        div_q, cnt_q;
        logic signed [DW-1:0] max_q, min_q, lim_hi, clamped, tgt_q, out_q;
        logic [DW:0]          diff, mag, next_val;
        logic                 en, hold, tick, limit, div_wr, busy;

        assign en       = ctrl[ch];
        assign hold     = ctrl[ch + 2];
        // Max is applied first, so an inverted window (min > max) always yields min.
        assign lim_hi   = ($signed(din[ch]) > max_q) ? max_q : $signed(din[ch]);
        assign clamped  = (lim_hi < min_q) ? min_q : lim_hi;
        assign step_eff = (step_q == '0) ? {{(DW-1){1'b0}}, 1'b1} : step_q;
        assign diff     = {tgt_q[DW-1], tgt_q} - {out_q[DW-1], out_q};
        assign mag      = diff[DW] ? (~diff + 1'b1) : diff;
        assign limit    = mag > {1'b0, step_eff};
        assign next_val = diff[DW] ? ({out_q[DW-1], out_q} - {1'b0, step_eff})
                                   : ({out_q[DW-1], out_q} + {1'b0, step_eff});
        assign tick     = cnt_q == div_q;
        assign div_wr   = sys_wen && addr == BASE + 20'h4;
        assign busy     = en && (out_q != tgt_q);

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                step_q <= {{(DW-1){1'b0}}, 1'b1};
                div_q  <= '0;
                max_q  <= {1'b0, {(DW-1){1'b1}}};
                min_q  <= {1'b1, {(DW-1){1'b0}}};
            end else if (sys_wen) begin
                case (addr)
                    BASE:          step_q <= sys_wdata[DW-1:0];
                    BASE + 20'h4:  div_q  <= sys_wdata[PW-1:0];
                    BASE + 20'h8:  max_q  <= sys_wdata[DW-1:0];
                    BASE + 20'hC:  min_q  <= sys_wdata[DW-1:0];
                    default: ;
                endcase
            end
        end

        // A limited step can never overshoot tgt, so next_val always fits in DW bits.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                tgt_q <= '0;
                out_q <= '0;
                cnt_q <= '0;
            end else begin
                tgt_q <= clamped;
                if (div_wr)
                    cnt_q <= '0;
                else if (!hold)
                    cnt_q <= (!en || tick) ? '0 : cnt_q + 1'b1;
                if (!hold) begin
                    if (!en)
                        out_q <= tgt_q;
                    else if (tick)
                        out_q <= limit ? next_val[DW-1:0] : tgt_q;
                end
            end
        end

`ifdef PID_SLEW_STAT_EN
        logic [15:0] lcnt_q;
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i)
                lcnt_q <= '0;
            else if (sys_wen && addr == 20'h08)
                lcnt_q <= '0;
            else if (en && !hold && tick && limit && lcnt_q != 16'hFFFF)
                lcnt_q <= lcnt_q + 1'b1;
        end
`endif
    end

    assign dat_a_o = g_ch[0].out_q;
    assign dat_b_o = g_ch[1].out_q;
    assign sys_err = 1'b0;

    always_comb begin
        rd_mux = '0;
        case (addr)
            20'h00: rd_mux[3:0]    = ctrl;
            20'h04: rd_mux[1:0]    = {g_ch[1].busy, g_ch[0].busy};
`ifdef PID_SLEW_STAT_EN
            20'h08: rd_mux         = {g_ch[1].lcnt_q, g_ch[0].lcnt_q};
`endif
            20'h10: rd_mux[DW-1:0] = g_ch[0].step_q;
            20'h14: rd_mux[PW-1:0] = g_ch[0].div_q;
            20'h18: rd_mux[DW-1:0] = g_ch[0].max_q;
            20'h1C: rd_mux[DW-1:0] = g_ch[0].min_q;
            20'h20: rd_mux[DW-1:0] = g_ch[1].step_q;
            20'h24: rd_mux[PW-1:0] = g_ch[1].div_q;
            20'h28: rd_mux[DW-1:0] = g_ch[1].max_q;
            20'h2C: rd_mux[DW-1:0] = g_ch[1].min_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sys_ack   <= 1'b0;
            sys_rdata <= '0;
        end else begin
            sys_ack <= sys_wen | sys_ren;
            if (sys_ren)
                sys_rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_red_pitaya_pid_slew.sv
// tb/tb_red_pitaya_pid_slew.sv - directed and randomized checks of the clamp/slew stage against an integer model
module tb_red_pitaya_pid_slew;
    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [13:0] dat_a_i = '0, dat_b_i = '0;
    logic [13:0] dat_a_o, dat_b_o;
    logic [31:0] sys_addr = '0, sys_wdata = '0;
    logic        sys_wen = 1'b0, sys_ren = 1'b0;
    logic [31:0] sys_rdata;
    logic        sys_err, sys_ack;

    int n_cmp = 0;
    int n_err = 0;

    int m_out[2], m_tgt[2], m_cnt[2], m_lcnt[2], m_step[2], m_div[2], m_max[2], m_min[2];
    int m_ctrl;

    logic [31:0] t4_exp [5] = '{32'h1000, 32'h0001, 32'h3002, 32'h2003, 32'h2000};

    red_pitaya_pid_slew #(.DW(14), .PW(16)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .dat_a_i(dat_a_i), .dat_b_i(dat_b_i),
        .dat_a_o(dat_a_o), .dat_b_o(dat_b_o),
        .sys_addr(sys_addr), .sys_wdata(sys_wdata),
        .sys_wen(sys_wen), .sys_ren(sys_ren),
        .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack)
    );

    always #5 clk_i = ~clk_i;

    function automatic int sx(input int v);
        int t;
        t = v & 32'h3FFF;
        return (t >= 8192) ? t - 16384 : t;
    endfunction

    function automatic int clampv(input int x, input int mx, input int mn);
        int r;
        r = x;
        if (r > mx) r = mx;
        if (r < mn) r = mn;
        return r;
    endfunction

    function automatic logic [31:0] m_bits(input int v);
        return 32'(v) & 32'h3FFF;
    endfunction

    function automatic logic [31:0] stat_exp();
        logic [31:0] r;
        r = '0;
        for (int c = 0; c < 2; c++)
            if (m_ctrl[c] && m_out[c] != m_tgt[c]) r[c] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] lcnt_exp();
`ifdef PID_SLEW_STAT_EN
        return {16'(m_lcnt[1]), 16'(m_lcnt[0])};
`else
        return 32'h0;
`endif
    endfunction

    // Reference: each channel clamps, then either follows tgt or moves by at most step per tick.
    always @(posedge clk_i or negedge rstn_i) begin
        int a, w, ch, off, s, d, x;
        if (!rstn_i) begin
            m_ctrl = 0;
            for (int c = 0; c < 2; c++) begin
                m_out[c] = 0; m_tgt[c] = 0; m_cnt[c] = 0; m_lcnt[c] = 0;
                m_step[c] = 1; m_div[c] = 0; m_max[c] = 8191; m_min[c] = -8192;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                x = sx((c == 0) ? int'(dat_a_i) : int'(dat_b_i));
                s = (m_step[c] == 0) ? 1 : m_step[c];
                if (!m_ctrl[c + 2]) begin
                    if (!m_ctrl[c]) begin
                        m_out[c] = m_tgt[c];
                        m_cnt[c] = 0;
                    end else if (m_cnt[c] == m_div[c]) begin
                        d = m_tgt[c] - m_out[c];
                        if (d > s || d < -s) begin
                            m_out[c] = m_out[c] + ((d > 0) ? s : -s);
                            if (m_lcnt[c] < 65535) m_lcnt[c]++;
                        end else begin
                            m_out[c] = m_tgt[c];
                        end
                        m_cnt[c] = 0;
                    end else begin
                        m_cnt[c]++;
                    end
                end
                m_tgt[c] = clampv(x, m_max[c], m_min[c]);
            end
            if (sys_wen) begin
                a = int'(sys_addr[19:0]);
                w = int'(sys_wdata & 32'h0000FFFF);
                if (a == 0) m_ctrl = w & 15;
                else if (a == 8) begin m_lcnt[0] = 0; m_lcnt[1] = 0; end
                else if (a >= 16 && a < 48 && (a % 4) == 0) begin
                    ch = (a - 16) / 16;
                    off = (a - 16) % 16;
                    case (off)
                        0:  m_step[ch] = w & 32'h3FFF;
                        4:  begin m_div[ch] = w; m_cnt[ch] = 0; end
                        8:  m_max[ch] = sx(w);
                        default: m_min[ch] = sx(w);
                    endcase
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step1();
        @(posedge clk_i);
        @(negedge clk_i);
        check("out_a", {18'h0, dat_a_o}, m_bits(m_out[0]));
        check("out_b", {18'h0, dat_b_o}, m_bits(m_out[1]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step1();
    endtask

    task automatic bus_wr(input logic [19:0] a, input logic [31:0] d);
        sys_addr = {12'h0, a}; sys_wdata = d; sys_wen = 1'b1;
        step1();
        sys_wen = 1'b0;
        check("wr_ack", {31'h0, sys_ack}, 32'h1);
    endtask

    task automatic bus_rd(input logic [19:0] a, input logic [31:0] exp, input string tag);
        sys_addr = {12'h0, a}; sys_ren = 1'b1;
        step1();
        sys_ren = 1'b0;
        check({tag, "_ack"}, {31'h0, sys_ack}, 32'h1);
        check(tag, sys_rdata, exp);
        check({tag, "_err"}, {31'h0, sys_err}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seen[$];
        logic [31:0] prev, obs;
        int          c4;

        repeat (3) @(negedge clk_i);
        check("rst_out_a", {18'h0, dat_a_o}, 32'h0);
        check("rst_out_b", {18'h0, dat_b_o}, 32'h0);
        check("rst_ack", {31'h0, sys_ack}, 32'h0);
        check("rst_rdata", sys_rdata, 32'h0);
        rstn_i = 1'b1;
        step1();
        bus_rd(20'h00, 32'h0, "rst_ctrl");
        bus_rd(20'h04, 32'h0, "rst_stat");
        bus_rd(20'h08, 32'h0, "rst_lcnt");
        bus_rd(20'h10, 32'h1, "rst_step_a");
        bus_rd(20'h14, 32'h0, "rst_div_a");
        bus_rd(20'h18, 32'h1FFF, "rst_max_a");
        bus_rd(20'h1C, 32'h2000, "rst_min_a");
        bus_rd(20'h20, 32'h1, "rst_step_b");
        bus_rd(20'h28, 32'h1FFF, "rst_max_b");
        bus_rd(20'h2C, 32'h2000, "rst_min_b");
        bus_rd(20'h40, 32'h0, "unmapped_rd");
        bus_wr(20'h40, 32'hFFFF_FFFF);
        bus_rd(20'h00, 32'h0, "unmapped_wr_ctrl");

        // Pass-through latency and clamp boundaries
        dat_a_i = 14'h0123;
        step1(); check("lat1", {18'h0, dat_a_o}, 32'h0);
        step1(); check("lat2", {18'h0, dat_a_o}, 32'h0123);
        bus_wr(20'h1C, 32'h3000);
        dat_a_i = 14'h2500;
        run(2); check("clamp_min", {18'h0, dat_a_o}, 32'h3000);
        bus_wr(20'h18, 32'h0800);
        dat_a_i = 14'h0FFF;
        run(2); check("clamp_max", {18'h0, dat_a_o}, 32'h0800);
        bus_wr(20'h1C, 32'h0900);
        dat_a_i = 14'h0850;
        run(2); check("min_wins", {18'h0, dat_a_o}, 32'h0900);
        bus_rd(20'h1C, 32'h0900, "rd_min_a");

        for (int i = 0; i < 16; i++) begin
            bus_wr(20'h18, $urandom_range(0, 16383));
            bus_wr(20'h1C, $urandom_range(0, 16383));
            bus_wr(20'h28, $urandom_range(0, 16383));
            bus_wr(20'h2C, $urandom_range(0, 16383));
            dat_a_i = 14'($urandom_range(0, 16383));
            dat_b_i = 14'($urandom_range(0, 16383));
            run(3);
        end
        bus_wr(20'h18, 32'h1FFF); bus_wr(20'h1C, 32'h2000);
        bus_wr(20'h28, 32'h1FFF); bus_wr(20'h2C, 32'h2000);

        // Ramp 0 -> 0x100, step 0x10 every 4 clk
        dat_a_i = 14'h0; dat_b_i = 14'h0;
        run(3);
        bus_wr(20'h10, 32'h10);
        bus_wr(20'h14, 32'h3);
        bus_wr(20'h00, 32'h1);
        dat_a_i = 14'h0100;
        run(10);
        bus_rd(20'h04, 32'h1, "stat_busy_mid");
        run(70);
        check("ramp_done", {18'h0, dat_a_o}, 32'h0100);
        bus_rd(20'h04, 32'h0, "stat_idle");

        // Full-scale ramp without wrap
        bus_wr(20'h00, 32'h0);
        bus_wr(20'h10, 32'h0FFF);
        bus_wr(20'h14, 32'h0);
        dat_a_i = 14'h1FFF;
        run(3);
        bus_wr(20'h00, 32'h1);
        dat_a_i = 14'h2000;
        prev = 32'h1FFF;
        for (int i = 0; i < 10; i++) begin
            step1();
            obs = {18'h0, dat_a_o};
            if (obs != prev) seen.push_back(obs);
            prev = obs;
        end
        check("fs_len", 32'(seen.size()), 32'h5);
        for (int i = 0; i < 5; i++)
            check($sformatf("fs_val%0d", i), (i < seen.size()) ? seen[i] : 32'hFFFF_FFFF, t4_exp[i]);

        // Hold on channel B mid-ramp
        bus_wr(20'h00, 32'h0);
        bus_wr(20'h20, 32'h5);
        bus_wr(20'h24, 32'h2);
        run(2);
        bus_wr(20'h00, 32'h2);
        dat_b_i = 14'h0200;
        run(20);
        bus_wr(20'h00, 32'hA);
        run(10);
        bus_rd(20'h04, stat_exp(), "stat_hold");
        bus_wr(20'h00, 32'h2);
        run(30);

        // Randomized ramps with mid-run register changes
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 2; c++) begin
                bus_wr(20'(16 + 16 * c), ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom_range(1, 32'h600));
                bus_wr(20'(20 + 16 * c), $urandom_range(0, 4));
                bus_wr(20'(24 + 16 * c), $urandom_range(32'h0800, 32'h1FFF));
                bus_wr(20'(28 + 16 * c), (16384 - $urandom_range(32'h0800, 32'h2000)) & 32'h3FFF);
            end
            c4 = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) c4 = c4 | 4;
            if ($urandom_range(0, 3) == 0) c4 = c4 | 8;
            bus_wr(20'h00, 32'(c4));
            dat_a_i = 14'($urandom_range(0, 16383));
            dat_b_i = 14'($urandom_range(0, 16383));
            run(15);
            bus_rd(20'h04, stat_exp(), "stat_rand");
            bus_wr(20'h10, $urandom_range(0, 32'h300));
            bus_wr(20'h24, $urandom_range(0, 3));
            run(15);
            bus_rd(20'h08, lcnt_exp(), "lcnt_rand");
        end

`ifdef PID_SLEW_STAT_EN
        bus_wr(20'h00, 32'h0);
        bus_wr(20'h18, 32'h1FFF); bus_wr(20'h1C, 32'h2000);
        dat_a_i = 14'h0;
        bus_wr(20'h10, 32'h10);
        bus_wr(20'h14, 32'h0);
        run(2);
        bus_wr(20'h00, 32'h1);
        bus_wr(20'h08, 32'h0);
        dat_a_i = 14'h00B0;
        run(20);
        bus_rd(20'h08, 32'h0000_000A, "lcnt_10");
        bus_wr(20'h08, 32'h1234);
        bus_rd(20'h08, 32'h0, "lcnt_clr");
`else
        bus_wr(20'h08, 32'hFFFF_FFFF);
        bus_rd(20'h08, 32'h0, "lcnt_absent");
`endif

        // Asynchronous reset mid-ramp
        bus_wr(20'h10, 32'h1);
        bus_wr(20'h14, 32'h2);
        bus_wr(20'h18, 32'h1FFF); bus_wr(20'h1C, 32'h2000);
        bus_wr(20'h28, 32'h1FFF); bus_wr(20'h2C, 32'h2000);
        bus_wr(20'h00, 32'h3);
        dat_a_i = 14'h1000;
        dat_b_i = 14'h3000;
        run(10);
        #2 rstn_i = 1'b0;
        #1;
        check("arst_out_a", {18'h0, dat_a_o}, 32'h0);
        check("arst_out_b", {18'h0, dat_b_o}, 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        dat_a_i = 14'h0;
        dat_b_i = 14'h0;
        step1();
        bus_rd(20'h00, 32'h0, "arst_ctrl");
        bus_rd(20'h10, 32'h1, "arst_step_a");
        bus_rd(20'h18, 32'h1FFF, "arst_max_a");
        bus_rd(20'h1C, 32'h2000, "arst_min_a");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
